// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage holding a DEPTH-entry {pc, inst} queue
// between the i-cache and the decoder. It owns the fetch PC, prefetches
// sequential words while the decoder stalls, and flushes everything on a
// jump redirect.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When defined, a word
// arriving while the queue is empty is presented downstream in the same
// cycle.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     ctrl_clk,
    input  logic                     ctrl_rst,
    output logic [31:0]              icache_addr,
    output logic                     icache_req,
    input  logic [31:0]              icache_data,
    input  logic                     icache_rdy,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              inst,
    output logic [31:0]              pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ctrl_fetcher_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Architectural state
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    // Last value shown downstream, held while the queue is empty
    logic [31:0]   r_last_pc;
    logic [31:0]   r_last_inst;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_bypass;
    logic          w_pop;
    logic          w_write;
    logic          w_mem_pop;
    logic [31:0]   w_out_pc;
    logic [31:0]   w_out_inst;

    // Handshake decode: request, push/pop qualification and head selection
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == CW'(DEPTH));
        icache_req = !ctrl_rst && !redirect_valid && !w_full;
        w_push     = icache_req && icache_rdy;
`ifdef FETCH_QUEUE_BYPASS_EN
        w_bypass   = w_empty && w_push;
`else
        w_bypass   = 1'b0;
`endif
        deq_valid  = !w_empty || w_bypass;
        w_pop      = deq_valid && deq_ready;
        // A bypassed word that is consumed immediately never enters storage
        w_write    = w_push && !(w_bypass && deq_ready);
        // Only pops of a stored entry move the read pointer
        w_mem_pop  = w_pop && !w_empty;
        if (w_bypass) begin
            w_out_pc   = r_fetch_pc;
            w_out_inst = icache_data;
        end else begin
            w_out_pc   = r_mem_pc[r_rd_ptr];
            w_out_inst = r_mem_inst[r_rd_ptr];
        end
        pc                 = deq_valid ? w_out_pc   : r_last_pc;
        inst               = deq_valid ? w_out_inst : r_last_inst;
        icache_addr        = r_fetch_pc;
        count              = r_count;
        ctrl_fetcher_stall = !deq_valid;
    end

    // Fetch PC, pointers and occupancy; redirect overrides all other updates
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_mem_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage entries, each cleared on reset and written at the write pointer
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
                if (ctrl_rst) begin
                    r_mem_pc[gi]   <= '0;
                    r_mem_inst[gi] <= '0;
                end else if (!redirect_valid && w_write && (r_wr_ptr == AW'(gi))) begin
                    r_mem_pc[gi]   <= r_fetch_pc;
                    r_mem_inst[gi] <= icache_data;
                end
            end
        end
    endgenerate

    // Capture whatever is presented so the head outputs hold when empty
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            r_last_pc   <= '0;
            r_last_inst <= '0;
        end else if (deq_valid) begin
            r_last_pc   <= w_out_pc;
            r_last_inst <= w_out_inst;
        end
    end

endmodule
